// File: rtl/mem_access_arb_pkg.sv
// Shared types and constants for the BAR memory-access arbiter.
// Region selects live in address bits [13:12].
package mem_access_arb_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int TAG_W_DEF  = 8;

   localparam logic [1:0] BAR0 = 2'b01;
   localparam logic [1:0] BAR2 = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD_WAIT = 2'd2,
      RD_CAP  = 2'd3
   } state_t;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } gnt_t;

endpackage

// File: rtl/mem_access_arb_rr_arb2.sv
// Two-requester round-robin arbiter.
// The requester that did not win last time wins a tie.
module rr_arb2
   import mem_access_arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req_wr,
   input  logic req_rd,
   output logic gnt_wr,
   output logic gnt_rd
);

   gnt_t last_grant;

   always_comb begin
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
      if (en) begin
         if (req_wr && req_rd) begin
            gnt_wr = (last_grant == GNT_RD);
            gnt_rd = (last_grant == GNT_WR);
         end else begin
            gnt_wr = req_wr;
            gnt_rd = req_rd;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= GNT_RD;
      end else if (gnt_wr) begin
         last_grant <= GNT_WR;
      end else if (gnt_rd) begin
         last_grant <= GNT_RD;
      end
   end

endmodule

// File: rtl/mem_access_arb.sv
// Serialises MWr and MRd accesses onto the single-ported BAR memory
// block and returns tagged read responses under valid/ready.
module mem_access_arb
   import mem_access_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int TAG_W  = TAG_W_DEF,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_req_valid,
   output logic              wr_req_ready,
   input  logic [ADDR_W-1:0] wr_req_addr,
   input  logic [7:0]        wr_req_be,
   input  logic [31:0]       wr_req_data,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [ADDR_W-1:0] rd_req_addr,
   input  logic [3:0]        rd_req_be,
   input  logic [TAG_W-1:0]  rd_req_tag,
   output logic              rd_rsp_valid,
   input  logic              rd_rsp_ready,
   output logic [31:0]       rd_rsp_data,
   output logic [TAG_W-1:0]  rd_rsp_tag,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_be,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [31:0]       mem_wr_data,
   input  logic              mem_wr_busy,
   output logic [3:0]        mem_rd_be,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [31:0]       mem_rd_data,
   output logic [CNT_W-1:0]  stat_wr_cnt,
   output logic [CNT_W-1:0]  stat_rd_cnt
);

   state_t           state;
   state_t           state_n;
   logic             win;
   logic             rd_elig;
   logic             wr_done;
   logic             gnt_wr;
   logic             gnt_rd;
   logic [TAG_W-1:0] tag_q;

   assign win     = (state == IDLE) || ((state == WR) && !mem_wr_busy);
   assign rd_elig = rd_req_valid && (!rd_rsp_valid || rd_rsp_ready);
   assign wr_done = (state == WR) && !mem_wr_busy;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (win),
      .req_wr (wr_req_valid),
      .req_rd (rd_elig),
      .gnt_wr (gnt_wr),
      .gnt_rd (gnt_rd)
   );

   assign wr_req_ready = gnt_wr;
   assign rd_req_ready = gnt_rd;

   always_comb begin
      state_n = IDLE;
      unique case (1'b1)
         (state == WR) && mem_wr_busy: state_n = WR;
         gnt_wr:                       state_n = WR;
         gnt_rd:                       state_n = RD_WAIT;
         state == RD_WAIT:             state_n = RD_CAP;
         default:                      state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mem_wr_en   <= 1'b0;
         mem_wr_be   <= '0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         mem_rd_be   <= '0;
         mem_rd_addr <= '0;
         tag_q       <= '0;
      end else begin
         state     <= state_n;
         mem_wr_en <= (state_n == WR);
         if (gnt_wr) begin
            mem_wr_be   <= wr_req_be;
            mem_wr_addr <= wr_req_addr;
            mem_wr_data <= wr_req_data;
         end
         // Read address stays put until the next read grant.
         if (gnt_rd) begin
            mem_rd_be   <= rd_req_be;
            mem_rd_addr <= rd_req_addr;
            tag_q       <= rd_req_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_rsp_valid <= 1'b0;
         rd_rsp_data  <= '0;
         rd_rsp_tag   <= '0;
         stat_wr_cnt  <= '0;
         stat_rd_cnt  <= '0;
      end else begin
         if (wr_done) begin
            stat_wr_cnt <= stat_wr_cnt + CNT_W'(1);
         end
         if (state == RD_CAP) begin
            rd_rsp_valid <= 1'b1;
            rd_rsp_data  <= mem_rd_data;
            rd_rsp_tag   <= tag_q;
            stat_rd_cnt  <= stat_rd_cnt + CNT_W'(1);
         end else if (rd_rsp_ready) begin
            rd_rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_arb.sv
// Bench for mem_access_arb: memory-block model, reference memory and
// scoreboard of tagged read responses.
module tb_mem_access_arb;

   localparam int AW = 14;
   localparam int TW = 8;
   localparam int CW = 4;
   localparam logic [31:0] MAGIC = 32'h0100_0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_req_valid = 1'b0;
   logic          wr_req_ready;
   logic [AW-1:0] wr_req_addr = '0;
   logic [7:0]    wr_req_be = '0;
   logic [31:0]   wr_req_data = '0;
   logic          rd_req_valid = 1'b0;
   logic          rd_req_ready;
   logic [AW-1:0] rd_req_addr = '0;
   logic [3:0]    rd_req_be = '0;
   logic [TW-1:0] rd_req_tag = '0;
   logic          rd_rsp_valid;
   logic          rd_rsp_ready = 1'b1;
   logic [31:0]   rd_rsp_data;
   logic [TW-1:0] rd_rsp_tag;
   logic          mem_wr_en;
   logic [7:0]    mem_wr_be;
   logic [AW-1:0] mem_wr_addr;
   logic [31:0]   mem_wr_data;
   logic          mem_wr_busy = 1'b0;
   logic [3:0]    mem_rd_be;
   logic [AW-1:0] mem_rd_addr;
   logic [31:0]   mem_rd_data = '0;
   logic [CW-1:0] stat_wr_cnt;
   logic [CW-1:0] stat_rd_cnt;

   mem_access_arb #(.ADDR_W(AW), .TAG_W(TW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
      .wr_req_addr(wr_req_addr), .wr_req_be(wr_req_be),
      .wr_req_data(wr_req_data),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_req_addr(rd_req_addr), .rd_req_be(rd_req_be),
      .rd_req_tag(rd_req_tag),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
      .rd_rsp_data(rd_rsp_data), .rd_rsp_tag(rd_rsp_tag),
      .mem_wr_en(mem_wr_en), .mem_wr_be(mem_wr_be),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_busy(mem_wr_busy), .mem_rd_be(mem_rd_be),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input bit ok, input string nm,
                      input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Memory block model (BAR2 RAM, BAR0 magic register) and reference copy.
   logic [31:0] env_mem [0:4095];
   logic [31:0] ref_mem [0:4095];

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] env_read(input logic [AW-1:0] a);
      if (a == 14'h1000) return MAGIC;
      if (a[13:12] == 2'b10) return env_mem[a[11:0]];
      return 32'h0;
   endfunction

   function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
      if (a == 14'h1000) return MAGIC;
      if (a[13:12] == 2'b10) return ref_mem[a[11:0]];
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      if (mem_wr_en && !mem_wr_busy && mem_wr_addr[13:12] == 2'b10)
         env_mem[mem_wr_addr[11:0]] <=
            merge(env_mem[mem_wr_addr[11:0]], mem_wr_data, mem_wr_be[3:0]);
      mem_rd_data <= env_read(mem_rd_addr);
   end

   // Monitor / scoreboard state.
   bit          flush_req = 0;
   int          cyc = 0;
   bit          p_valid = 0, p_hs = 0;
   logic [31:0] p_data;
   logic [7:0]  p_tag;
   int          rd_hold = 0;
   bit          wr_pend = 0;
   logic [AW-1:0] w_addr;
   logic [31:0] w_data;
   logic [7:0]  w_be;
   int          wr_done = 0, rd_done = 0;
   bit          last_rd = 1;
   logic [39:0] rsp_q[$];
   int          due_q[$];

   always @(negedge clk) begin : mon
      bit rd_elig, wr_acc, rd_acc, hs, new_rsp, win;
      logic [39:0] e;
      if (rst_n) begin
         if (flush_req) begin
            p_valid = 0; p_hs = 0; rd_hold = 0; wr_pend = 0;
            wr_done = 0; rd_done = 0; last_rd = 1;
            rsp_q.delete(); due_q.delete();
            flush_req = 0;
         end
         cyc++;
         rd_elig = rd_req_valid && (!rd_rsp_valid || rd_rsp_ready);
         wr_acc  = wr_req_valid && wr_req_ready;
         rd_acc  = rd_req_valid && rd_req_ready;
         hs      = rd_rsp_valid && rd_rsp_ready;
         new_rsp = rd_rsp_valid && (!p_valid || p_hs);
         win     = (rd_hold == 0) && (!wr_pend || !mem_wr_busy);

         chk(stat_wr_cnt == CW'(wr_done), "stat_wr", stat_wr_cnt, CW'(wr_done));
         if (due_q.size() != 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            rd_done++;
            chk(new_rsp, "rsp_latency", new_rsp, 1);
         end else begin
            chk(!new_rsp, "rsp_spurious", new_rsp, 0);
         end
         chk(stat_rd_cnt == CW'(rd_done), "stat_rd", stat_rd_cnt, CW'(rd_done));

         if (p_valid && !p_hs)
            chk(rd_rsp_valid && rd_rsp_data == p_data && rd_rsp_tag == p_tag,
                "rsp_hold", {rd_rsp_valid, rd_rsp_tag, rd_rsp_data},
                {1'b1, p_tag, p_data});
         if (hs) begin
            chk(rsp_q.size() != 0, "rsp_extra", rsp_q.size(), 1);
            if (rsp_q.size() != 0) begin
               e = rsp_q.pop_front();
               chk({rd_rsp_tag, rd_rsp_data} == e, "rsp_data",
                   {rd_rsp_tag, rd_rsp_data}, e);
            end
         end

         chk(!(wr_req_ready && !wr_req_valid) && !(rd_req_ready && !rd_elig)
             && !(wr_req_ready && rd_req_ready), "ready_legal",
             {wr_req_ready, rd_req_ready}, {wr_req_valid, rd_elig});
         chk((wr_req_ready || rd_req_ready) == (win && (wr_req_valid || rd_elig)),
             "accept_window", {wr_req_ready, rd_req_ready},
             win && (wr_req_valid || rd_elig));
         if (win && wr_req_valid && rd_elig)
            chk(rd_req_ready == !last_rd, "arb_rr", rd_req_ready, !last_rd);
         if (rd_hold > 0)
            chk(!mem_wr_en, "wr_during_rd", mem_wr_en, 0);

         if (wr_pend) begin
            chk(mem_wr_en && mem_wr_addr == w_addr && mem_wr_data == w_data
                && mem_wr_be == w_be, "wr_issue",
                {mem_wr_en, mem_wr_addr, mem_wr_be, mem_wr_data},
                {1'b1, w_addr, w_be, w_data});
            if (!mem_wr_busy) begin
               wr_pend = 0;
               wr_done++;
            end
         end else begin
            chk(!mem_wr_en, "wr_spurious", mem_wr_en, 0);
         end

         if (rd_hold > 0) rd_hold--;
         if (wr_acc) begin
            if (wr_req_addr[13:12] == 2'b10)
               ref_mem[wr_req_addr[11:0]] =
                  merge(ref_mem[wr_req_addr[11:0]], wr_req_data, wr_req_be[3:0]);
            wr_pend = 1;
            w_addr = wr_req_addr; w_data = wr_req_data; w_be = wr_req_be;
            last_rd = 0;
         end
         if (rd_acc) begin
            rsp_q.push_back({rd_req_tag, ref_read(rd_req_addr)});
            due_q.push_back(cyc + 3);
            rd_hold = 2;
            last_rd = 1;
         end
         p_valid = rd_rsp_valid; p_hs = hs;
         p_data = rd_rsp_data; p_tag = rd_rsp_tag;
      end
   end

   // Stimulus helpers.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_wr(input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [7:0] be, output int waited);
      wr_req_addr = a; wr_req_data = d; wr_req_be = be;
      wr_req_valid = 1'b1;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!wr_req_ready && waited < 50);
      chk(wr_req_ready, "wr_timeout", waited, 50);
      tick();
      wr_req_valid = 1'b0;
   endtask

   task automatic do_rd(input logic [AW-1:0] a, input logic [TW-1:0] t);
      int waited;
      rd_req_addr = a; rd_req_tag = t; rd_req_be = 4'hF;
      rd_req_valid = 1'b1;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!rd_req_ready && waited < 50);
      chk(rd_req_ready, "rd_timeout", waited, 50);
      tick();
      rd_req_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      flush_req = 1;
      #2 rst_n = 1'b1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(3) == 0) return 14'h1000;
      return {2'b10, 8'h00, 4'($urandom_range(15))};
   endfunction

   task automatic run_cycles(input int n, input int p_wr, input int p_rd,
                             input int p_busy, input int p_rdy);
      bit wa, ra;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wa = wr_req_valid && wr_req_ready;
         ra = rd_req_valid && rd_req_ready;
         tick();
         if (!wr_req_valid || wa) begin
            wr_req_valid = ($urandom_range(99) < p_wr);
            wr_req_addr = rnd_addr();
            wr_req_data = $urandom;
            wr_req_be = 8'($urandom);
         end
         if (!rd_req_valid || ra) begin
            rd_req_valid = ($urandom_range(99) < p_rd);
            rd_req_addr = rnd_addr();
            rd_req_tag = 8'($urandom);
            rd_req_be = 4'($urandom);
         end
         mem_wr_busy = ($urandom_range(99) < p_busy);
         rd_rsp_ready = ($urandom_range(99) < p_rdy);
      end
   endtask

   task automatic drain();
      run_cycles(30, 0, 0, 0, 100);
      chk(rsp_q.size() == 0 && due_q.size() == 0 && !wr_pend, "drain",
          rsp_q.size() + due_q.size(), 0);
   endtask

   logic [121:0] outs;
   assign outs = {mem_wr_en, mem_wr_be, mem_wr_addr, mem_wr_data, mem_rd_be,
                  mem_rd_addr, rd_rsp_valid, rd_rsp_data, rd_rsp_tag,
                  stat_wr_cnt, stat_rd_cnt};

   initial begin
      int w, n, grants;
      bit exp_w;
      for (int i = 0; i < 4096; i++) begin
         env_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hC0DE_0000;
         ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hC0DE_0000;
      end
      repeat (2) @(negedge clk);
      chk(outs == '0 && !wr_req_ready && !rd_req_ready, "reset_state", outs, 0);
      tick();
      rst_n = 1'b1;

      // Write then read back at BAR2.
      do_wr(14'h2004, 32'hDEAD_BEEF, 8'h0F, w);
      do_rd(14'h2004, 8'h11);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rd_rsp_valid && n < 10);
      chk(n == 3 && rd_rsp_data == 32'hDEAD_BEEF && rd_rsp_tag == 8'h11,
          "wr_rd_back", {n, rd_rsp_tag, rd_rsp_data}, {32'd3, 8'h11, 32'hDEAD_BEEF});
      tick();
      drain();

      // Continuous contention from a fresh reset.
      do_reset();
      wr_req_addr = 14'h2008; wr_req_data = 32'h1234_5678; wr_req_be = 8'hFF;
      rd_req_addr = 14'h2008; rd_req_tag = 8'h40; rd_req_be = 4'hF;
      wr_req_valid = 1'b1; rd_req_valid = 1'b1;
      exp_w = 1; grants = 0;
      for (int i = 0; i < 40 && grants < 8; i++) begin
         bit wa, ra;
         @(negedge clk);
         wa = wr_req_ready; ra = rd_req_ready;
         if (wa || ra) begin
            chk(wa == exp_w, "alternate", wa, exp_w);
            exp_w = !exp_w;
            grants++;
         end
         tick();
         if (wa) wr_req_data = $urandom;
         if (ra) rd_req_tag = rd_req_tag + 8'd1;
      end
      chk(grants == 8, "alternate_count", grants, 8);
      wr_req_valid = 1'b0; rd_req_valid = 1'b0;
      drain();

      // Response back-pressure with a second read waiting.
      rd_rsp_ready = 1'b0;
      do_rd(14'h1000, 8'h21);
      rd_req_addr = 14'h2004; rd_req_tag = 8'h22; rd_req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk(!rd_req_ready, "rd_blocked", rd_req_ready, 0);
         tick();
      end
      chk(rd_rsp_valid && rd_rsp_data == MAGIC && rd_rsp_tag == 8'h21,
          "magic_hold", {rd_rsp_valid, rd_rsp_tag, rd_rsp_data},
          {1'b1, 8'h21, MAGIC});
      rd_rsp_ready = 1'b1;
      @(negedge clk);
      chk(rd_req_ready, "rd_on_handshake", rd_req_ready, 1);
      tick();
      rd_req_valid = 1'b0;
      drain();

      // Write stalled by mem_wr_busy for three cycles.
      mem_wr_busy = 1'b1;
      do_wr(14'h200C, 32'hA5A5_5A5A, 8'h03, w);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n += int'(mem_wr_en);
         tick();
      end
      mem_wr_busy = 1'b0;
      @(negedge clk);
      n += int'(mem_wr_en);
      tick();
      @(negedge clk);
      chk(n == 4 && !mem_wr_en, "busy_hold", n, 4);
      drain();

      // Write requested while a read is in flight.
      do_rd(14'h200C, 8'h33);
      do_wr(14'h200C, 32'h0BAD_F00D, 8'h0F, w);
      chk(w == 3, "wr_after_rd", w, 3);
      drain();

      // Asynchronous reset during RD_WAIT.
      do_rd(14'h2004, 8'h44);
      #1 rst_n = 1'b0;
      #1 chk(outs == '0, "async_reset", outs, 0);
      flush_req = 1;
      #1 rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n += int'(rd_rsp_valid);
         tick();
      end
      chk(n == 0, "no_rsp_after_reset", n, 0);

      // Randomized traffic.
      run_cycles(400, 50, 50, 30, 70);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
